// File: rtl/ram_copy_pkg.sv
// Shared encodings for the RAM block copier: FSM states and copy-direction flags.
package ram_copy_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic DIR_ASC  = 1'b0;
   localparam logic DIR_DESC = 1'b1;

endpackage

// File: rtl/ram_block_copier.sv
// Copies a block of RAM words from src to dst through the single RAM port,
// two cycles per word (read, then write), with memmove-safe ordering.
module ram_block_copier
   import ram_copy_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 12,
   parameter int LEN_WIDTH     = 12
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [ADDRESS_WIDTH-1:0] src_base,
   input  logic [ADDRESS_WIDTH-1:0] dst_base,
   input  logic [LEN_WIDTH-1:0]     len,
   output logic                     busy,
   output logic                     done,
   output logic                     mem_wEn,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_dataIn,
   input  logic [DATA_WIDTH-1:0]    mem_dataOut,
   output state_t                   dbg_state
);

   state_t                   state_q;
   logic [ADDRESS_WIDTH-1:0] src_q, dst_q, addr_q;
   logic [LEN_WIDTH-1:0]     len_q, idx_q;
   logic                     dir_q, wen_q, done_q;

   logic [ADDRESS_WIDTH-1:0] diff_d, rd_first_d, wr_addr_d, rd_next_d;
   logic [LEN_WIDTH-1:0]     idx_d;
   logic                     dir_d, last_d;

   // Offset of word i: i when ascending, len-1-i when descending.
   function automatic logic [ADDRESS_WIDTH-1:0] word_off(input logic dir,
                                                        input logic [LEN_WIDTH-1:0] n,
                                                        input logic [LEN_WIDTH-1:0] i);
      logic [LEN_WIDTH-1:0] o;
      o = (dir == DIR_DESC) ? (n - LEN_WIDTH'(1) - i) : i;
      return ADDRESS_WIDTH'(o);
   endfunction

   always_comb begin
      diff_d     = dst_base - src_base;
      dir_d      = ((diff_d != '0) && (32'(diff_d) < 32'(len))) ? DIR_DESC : DIR_ASC;
      rd_first_d = src_base + word_off(dir_d, len, '0);
      idx_d      = idx_q + LEN_WIDTH'(1);
      wr_addr_d  = dst_q + word_off(dir_q, len_q, idx_q);
      rd_next_d  = src_q + word_off(dir_q, len_q, idx_d);
      last_d     = (idx_q == (len_q - LEN_WIDTH'(1)));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         dir_q   <= DIR_ASC;
         addr_q  <= '0;
         wen_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               wen_q  <= 1'b0;
               addr_q <= '0;
               done_q <= 1'b0;
               if (start) begin
                  src_q <= src_base;
                  dst_q <= dst_base;
                  len_q <= len;
                  dir_q <= dir_d;
                  idx_q <= '0;
                  if (len == '0) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_RD;
                     addr_q  <= rd_first_d;
                  end
               end
            end
            ST_RD: begin
               state_q <= ST_WR;
               addr_q  <= wr_addr_d;
               wen_q   <= 1'b1;
            end
            ST_WR: begin
               wen_q <= 1'b0;
               if (last_d) begin
                  state_q <= ST_DONE;
                  addr_q  <= '0;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= ST_RD;
                  idx_q   <= idx_d;
                  addr_q  <= rd_next_d;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               addr_q  <= '0;
               wen_q   <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               wen_q   <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // The RAM holds dataOut through the write cycle, so it can feed dataIn directly.
   assign mem_dataIn = (state_q == ST_WR) ? mem_dataOut : '0;
   assign busy       = (state_q != ST_IDLE);
   assign done       = done_q;
   assign mem_wEn    = wen_q;
   assign mem_addr   = addr_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_ram_block_copier.sv
// Bench for ram_block_copier: behavioural RAM, memmove reference model,
// directed table, hand-written corner sequences and random commands.
module tb_ram_block_copier;
   import ram_copy_pkg::*;

   localparam int DW = 32;
   localparam int AW = 12;
   localparam int LW = 12;
   localparam int DEPTH = 1 << AW;
   localparam int BUDGET = 2000;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic          start;
   logic [AW-1:0] src_base, dst_base;
   logic [LW-1:0] len;
   logic          busy, done, mem_wEn;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_dataIn, mem_dataOut;
   state_t        dbg_state;

   ram_block_copier #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .LEN_WIDTH(LW)) dut (
      .clk(clk), .reset(reset), .start(start),
      .src_base(src_base), .dst_base(dst_base), .len(len),
      .busy(busy), .done(done), .mem_wEn(mem_wEn), .mem_addr(mem_addr),
      .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut), .dbg_state(dbg_state)
   );

   // ---------------- behavioural single-port RAM ----------------
   logic [DW-1:0] ram [DEPTH];
   logic [DW-1:0] ram_q;
   logic          pl_en;
   logic [AW-1:0] pl_addr;
   logic [DW-1:0] pl_data;
   assign mem_dataOut = ram_q;

   always @(posedge clk) begin
      if (pl_en) ram[pl_addr] <= pl_data;
      else if (mem_wEn) ram[mem_addr] <= mem_dataIn;
      else ram_q <= ram[mem_addr];
   end

   // ---------------- reference model and scoreboard ----------------
   logic [DW-1:0] model [DEPTH];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] rd_q[$];
   logic [DW-1:0] wr_q[$];
   int wr_cnt, busy_cnt, done_cnt, stray_wen;
   int checks = 0;
   int passes = 0;

   always @(negedge clk) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (mem_wEn) begin
         wr_q.push_back(DW'(mem_addr));
         wr_cnt++;
         if (!busy) stray_wen++;
      end
      if (busy && !mem_wEn && !done) rd_q.push_back(DW'(mem_addr));
   end

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // memmove semantics: snapshot the first n source words, then write them out.
   task automatic model_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                             input int n, input int words_done);
      logic [DW-1:0] snap[$];
      for (int j = 0; j < n; j++) snap.push_back(model[AW'(int'(s) + j)]);
      for (int j = 0; j < words_done; j++) model[AW'(int'(d) + j)] = snap[j];
   endtask

   function automatic int ram_diffs();
      int m = 0;
      for (int i = 0; i < DEPTH; i++) if (ram[i] !== model[i]) m++;
      return m;
   endfunction

   task automatic clear_mon();
      rd_q.delete(); wr_q.delete(); exp_q.delete();
      wr_cnt = 0; busy_cnt = 0; done_cnt = 0;
   endtask

   task automatic check_queue(input string name, input logic [DW-1:0] got[$]);
      check({name, "_len"}, DW'(got.size()), DW'(exp_q.size()));
      for (int j = 0; j < exp_q.size() && j < got.size(); j++)
         check(name, got[j], exp_q[j]);
   endtask

   // ---------------- driver tasks ----------------
   task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      model[a] = d;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   // Issues one command, waits for done, then checks timing, counts and RAM image.
   task automatic run_cmd(input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [LW-1:0] n, input int exp_lat);
      int lat;
      clear_mon();
      model_copy(s, d, int'(n), int'(n));
      src_base = s; dst_base = d; len = n; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      src_base = $urandom; dst_base = $urandom; len = LW'($urandom_range(0, 9));
      lat = -1;
      for (int c = 1; c <= BUDGET; c++) begin
         @(negedge clk);
         if (done) begin lat = c; break; end
      end
      check("done_latency", DW'(lat), DW'(exp_lat));
      @(negedge clk);
      check("busy_after_done", DW'(busy), 0);
      @(posedge clk); #1;
      check("write_count", DW'(wr_cnt), DW'(n));
      check("busy_cycles", DW'(busy_cnt), DW'(2 * int'(n) + 1));
      check("done_pulses", DW'(done_cnt), 1);
      check("ram_image", DW'(ram_diffs()), 0);
   endtask

   // ---------------- directed table ----------------
   typedef struct packed {
      logic [AW-1:0] src;
      logic [AW-1:0] dst;
      logic [LW-1:0] n;
      logic [7:0]    exp_lat;
   } vec_t;
   vec_t vecs[7];

   initial begin
      #500000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; start = 1'b0; src_base = '0; dst_base = '0; len = '0;
      pl_en = 1'b0; pl_addr = '0; pl_data = '0;
      stray_wen = 0;

      vecs[0] = '{src: 12'h010, dst: 12'h100, n: 12'd4, exp_lat: 8'd9};   // basic
      vecs[1] = '{src: 12'h020, dst: 12'h022, n: 12'd4, exp_lat: 8'd9};   // forward overlap
      vecs[2] = '{src: 12'h042, dst: 12'h040, n: 12'd4, exp_lat: 8'd9};   // backward overlap
      vecs[3] = '{src: 12'h030, dst: 12'h030, n: 12'd3, exp_lat: 8'd7};   // self copy
      vecs[4] = '{src: 12'hFFE, dst: 12'h200, n: 12'd4, exp_lat: 8'd9};   // wrap
      vecs[5] = '{src: 12'h050, dst: 12'h060, n: 12'd0, exp_lat: 8'd1};   // zero length
      vecs[6] = '{src: 12'hFFC, dst: 12'h001, n: 12'd8, exp_lat: 8'd17};  // overlap across wrap

      for (int i = 0; i < DEPTH; i++) poke(AW'(i), $urandom);
      for (int j = 0; j < 4; j++) begin
         poke(AW'(12'h010 + j), DW'(32'hA0 + j));
         poke(AW'(12'h020 + j), DW'(1 + j));
         poke(AW'(12'h042 + j), DW'(5 + j));
      end

      @(negedge clk);
      check("reset_busy", DW'(busy), 0);
      check("reset_done", DW'(done), 0);
      check("reset_wen", DW'(mem_wEn), 0);
      check("reset_addr", DW'(mem_addr), 0);
      check("reset_datain", mem_dataIn, 0);
      check("reset_state", DW'(dbg_state), DW'(ST_IDLE));
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      for (int r = 0; r < 7; r++) begin
         run_cmd(vecs[r].src, vecs[r].dst, vecs[r].n, int'(vecs[r].exp_lat));
         case (r)
            0: begin
               for (int j = 0; j < 4; j++) begin
                  check("basic_dst", ram[12'h100 + j], DW'(32'hA0 + j));
                  check("basic_src_kept", ram[12'h010 + j], DW'(32'hA0 + j));
               end
            end
            1: begin
               exp_q = '{32'h025, 32'h024, 32'h023, 32'h022};
               check_queue("fwd_write_order", wr_q);
               for (int j = 0; j < 4; j++) check("fwd_dst", ram[12'h022 + j], DW'(1 + j));
            end
            2: begin
               exp_q = '{32'h040, 32'h041, 32'h042, 32'h043};
               check_queue("bwd_write_order", wr_q);
               for (int j = 0; j < 4; j++) check("bwd_dst", ram[12'h040 + j], DW'(5 + j));
            end
            4: begin
               exp_q = '{32'hFFE, 32'hFFF, 32'h000, 32'h001};
               check_queue("wrap_read_order", rd_q);
               exp_q = '{32'h200, 32'h201, 32'h202, 32'h203};
               check_queue("wrap_write_order", wr_q);
            end
            default: ;
         endcase
      end

      // start held high with changing operands during a len=3 copy
      begin
         int lat;
         clear_mon();
         model_copy(12'h300, 12'h310, 3, 3);
         src_base = 12'h300; dst_base = 12'h310; len = 12'd3; start = 1'b1;
         @(posedge clk); #1;
         src_base = 12'h400; dst_base = 12'h410; len = 12'd5;
         lat = -1;
         for (int c = 1; c <= BUDGET; c++) begin
            @(negedge clk);
            if (done) begin lat = c; start = 1'b0; break; end
         end
         check("ignored_start_latency", DW'(lat), 32'd7);
         repeat (6) @(posedge clk);
         #1;
         check("ignored_start_writes", DW'(wr_cnt), 32'd3);
         check("ignored_start_done", DW'(done_cnt), 32'd1);
         check("ignored_start_idle", DW'(busy), 0);
         check("ignored_start_ram", DW'(ram_diffs()), 0);
      end

      // reset on the write cycle of word 2 of a len=8 copy
      begin
         clear_mon();
         model_copy(12'h500, 12'h600, 8, 3);
         src_base = 12'h500; dst_base = 12'h600; len = 12'd8; start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         repeat (6) @(negedge clk);
         check("rst_mid_wr_wen", DW'(mem_wEn), 1);
         check("rst_mid_wr_addr", DW'(mem_addr), 32'h602);
         reset = 1'b1;
         @(negedge clk);
         check("rst_mid_busy", DW'(busy), 0);
         check("rst_mid_wen", DW'(mem_wEn), 0);
         reset = 1'b0;
         repeat (4) @(posedge clk);
         #1;
         check("rst_mid_writes", DW'(wr_cnt), 32'd3);
         check("rst_mid_no_done", DW'(done_cnt), 0);
         check("rst_mid_ram", DW'(ram_diffs()), 0);
      end

      // random commands, biased toward overlapping regions
      for (int t = 0; t < 24; t++) begin
         logic [AW-1:0] s, d;
         logic [LW-1:0] n;
         int mode;
         s = AW'($urandom);
         n = LW'($urandom_range(0, 40));
         mode = $urandom_range(0, 2);
         if (mode == 0) d = AW'($urandom);
         else if (mode == 1) d = s + AW'($urandom_range(0, int'(n) + 1));
         else d = s - AW'($urandom_range(0, int'(n) + 1));
         run_cmd(s, d, n, 2 * int'(n) + 1);
      end

      check("no_wen_outside_busy", DW'(stray_wen), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/ram_block_copier.md
# ram_block_copier

Memory-side initiator that copies a contiguous block of words from one region of the single-port RAM to another. It drives the RAM's `wEn`/`addr`/`dataIn` port and consumes its registered `dataOut`, so the RAM itself needs no multi-word copy logic. It sits between the control logic (which issues copy commands) and the RAM port mux. While `busy` is high, the mux gives the copier ownership of the port.

## Interface
- `DATA_WIDTH`, 32, RAM word width
- `ADDRESS_WIDTH`, 12, RAM address width; all address arithmetic is modulo 2^ADDRESS_WIDTH
- `LEN_WIDTH`, 12, width of the word-count field
- `clk`  in  1  single clock; all state changes on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  command strobe; sampled only in IDLE
- `src_base`  in  ADDRESS_WIDTH  first source word address
- `dst_base`  in  ADDRESS_WIDTH  first destination word address
- `len`  in  LEN_WIDTH  number of words to copy; 0 is legal
- `busy`  out  1  high whenever state ≠ IDLE
- `done`  out  1  one-cycle pulse when a command completes
- `mem_wEn`  out  1  to RAM `wEn`
- `mem_addr`  out  ADDRESS_WIDTH  to RAM `addr`
- `mem_dataIn`  out  DATA_WIDTH  to RAM `dataIn`
- `mem_dataOut`  in  DATA_WIDTH  from RAM `dataOut`

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE, `start`=1: latch `src_base`, `dst_base`, `len` and the copy direction.
  - `len`=0 → DONE.
  - Otherwise → RD, with index 0.
- IDLE, `start`=0: stay in IDLE.
- Direction is descending when `dst_base` ≠ `src_base` and (`dst_base` − `src_base`) mod 2^ADDRESS_WIDTH < `len`. Otherwise it is ascending.
  - Ascending offset for word i is i.
  - Descending offset for word i is `len`−1−i.
  - Either way, overlapping copies never read an already-overwritten word.
- RD: `mem_addr` = src + offset, `mem_wEn`=0. Always → WR.
- WR: `mem_addr` = dst + offset, `mem_wEn`=1, `mem_dataIn` = `mem_dataOut` (combinational pass-through). The RAM holds `dataOut` during a write cycle, so the value is stable.
  - If i = `len`−1 → DONE.
  - Else i ← i+1 → RD.
- DONE: `done`=1, `mem_wEn`=0. Always → IDLE.
- `start` outside IDLE is ignored. Latched operands are not affected by input changes after acceptance.
- `src_base` = `dst_base` with `len` > 0 performs a full ascending copy; the data is unchanged.
- Addresses wrap past 2^ADDRESS_WIDTH−1 to 0 silently.
- Outputs in IDLE: `mem_wEn`=0, `mem_addr`=0, `mem_dataIn`=0.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `mem_wEn`=0, `mem_addr`=0, index=0, latched operands=0.
- Reset asserted mid-copy: IDLE at the next edge, `mem_wEn`=0 from that cycle on. Words already written stay written. No `done` pulse.
- `start` sampled at edge k:
  - RD occupies cycle k+1 and WR occupies cycle k+2 for word 0.
  - Word i's RD is cycle k+1+2i.
  - DONE (`done`=1) is cycle k+1+2·`len`.
  - `busy` falls at cycle k+2+2·`len`.
- `len`=0: DONE in cycle k+1; `busy` high for exactly that one cycle.
- Throughput: 2 cycles per word. One RAM access per cycle, so there is no port conflict.
- Back-to-back commands: the next `start` can be accepted in the first IDLE cycle after DONE.

## Structure
- Package `ram_copy_pkg`: state encoding constants (IDLE, RD, WR, DONE) and the ascending/descending direction flag constants.
- Single flat module. The offset/address adder is inline; no sub-module.
- The port mux to the RAM is outside this block.

## Test plan
- Basic ascending copy: preload RAM[0x010..0x013] = 0xA0..0xA3; start src=0x010, dst=0x100, len=4 → RAM[0x100..0x103] = 0xA0..0xA3; `done` at cycle k+9; source unchanged.
- Forward overlap: RAM[0x020..0x023] = 1,2,3,4; src=0x020, dst=0x022, len=4 → descending order used; RAM[0x022..0x025] = 1,2,3,4.
- Backward overlap: RAM[0x042..0x045] = 5,6,7,8; src=0x042, dst=0x040, len=4 → ascending; RAM[0x040..0x043] = 5,6,7,8.
- Zero length and ignored start: `len`=0 → `done` at k+1, no `mem_wEn` pulse. Then a len=3 copy with `start` re-asserted and operands changed mid-copy → the original copy completes unaltered, and no second command is accepted.
- Wrap-around: src=0xFFE, dst=0x200, len=4 → reads 0xFFE, 0xFFF, 0x000, 0x001 in that order; writes 0x200..0x203.
- Reset mid-copy: assert `reset` on the WR cycle of word 2 of a len=8 copy → next cycle `busy`=0, `mem_wEn`=0; words 0–2 copied, words 3–7 untouched, no `done`.
